// File: rtl/renode_ahb_manager_engine_if.sv
// Command/response and AHB-Lite manager signal bundle.
// master = engine side, slave = Renode glue plus subordinate side.
interface renode_ahb_manager_engine_if #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [AddressWidth-1:0] cmd_addr;
  logic [2:0]              cmd_size;
  logic [DataWidth-1:0]    cmd_wdata;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [DataWidth-1:0]    resp_rdata;
  logic                    resp_error;
  logic [AddressWidth-1:0] haddr;
  logic [1:0]              htrans;
  logic                    hwrite;
  logic [2:0]              hsize;
  logic [2:0]              hburst;
  logic [3:0]              hprot;
  logic                    hmastlock;
  logic [DataWidth-1:0]    hwdata;
  logic                    hready;
  logic                    hresp;
  logic [DataWidth-1:0]    hrdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr,
    input  cmd_size, cmd_wdata, resp_ready,
    input  hready, hresp, hrdata,
    output cmd_ready, resp_valid,
    output resp_rdata, resp_error,
    output haddr, htrans, hwrite, hsize,
    output hburst, hprot, hmastlock, hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr,
    output cmd_size, cmd_wdata, resp_ready,
    output hready, hresp, hrdata,
    input  cmd_ready, resp_valid,
    input  resp_rdata, resp_error,
    input  haddr, htrans, hwrite, hsize,
    input  hburst, hprot, hmastlock, hwdata
  );
endinterface

// File: rtl/renode_ahb_manager_engine.sv
// AHB-Lite manager: one SINGLE transfer per command,
// result returned on a valid/ready response port.
module renode_ahb_manager_engine #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32
) (
  input logic hclk,
  input logic hresetn,
  renode_ahb_manager_engine_if.master bus
);

  localparam logic [2:0] MaxSize =
    3'($clog2(DataWidth / 8));

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t               state;
  logic [DataWidth-1:0] wdata_q;
  logic [2:0]           lsb_mask;
  logic                 size_ok;
  logic                 align_ok;
  logic                 cmd_ok;

  // Only sizes up to MaxSize (<= 3) pass, so three LSBs
  // are enough to judge alignment.
  assign lsb_mask = (3'b001 << bus.cmd_size) - 3'b001;
  assign size_ok  = bus.cmd_size <= MaxSize;
  assign align_ok = (bus.cmd_addr[2:0] & lsb_mask) == 3'b000;
  assign cmd_ok   = size_ok && align_ok;

  assign bus.cmd_ready = (state == IDLE) && hresetn;
  assign bus.hburst    = 3'b000;
  assign bus.hprot     = 4'b0011;
  assign bus.hmastlock = 1'b0;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state          <= IDLE;
      wdata_q        <= '0;
      bus.htrans     <= TransIdle;
      bus.haddr      <= '0;
      bus.hwrite     <= 1'b0;
      bus.hsize      <= 3'b000;
      bus.hwdata     <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_error <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (cmd_ok) begin
              bus.htrans <= TransNonseq;
              bus.haddr  <= bus.cmd_addr;
              bus.hwrite <= bus.cmd_write;
              bus.hsize  <= bus.cmd_size;
              wdata_q    <= bus.cmd_wdata;
              state      <= ADDR;
            end else begin
              // Rejected locally: never reaches the bus.
              bus.resp_error <= 1'b1;
              bus.resp_rdata <= '0;
              bus.resp_valid <= 1'b1;
              state          <= RESP;
            end
          end
        end
        ADDR: begin
          if (bus.hready) begin
            bus.htrans <= TransIdle;
            bus.hwdata <= bus.hwrite ? wdata_q : '0;
            state      <= DATA;
          end
        end
        DATA: begin
          // Nothing is pipelined behind us, so the first
          // ERROR cycle is simply waited out.
          if (bus.hready) begin
            bus.resp_error <= bus.hresp;
            bus.resp_rdata <=
              (!bus.hwrite && !bus.hresp) ? bus.hrdata : '0;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.hwdata     <= '0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_renode_ahb_manager_engine.sv
// Directed bench for renode_ahb_manager_engine with a
// transaction-level reference model checked every cycle.
module tb_renode_ahb_manager_engine;

  logic hclk    = 1'b0;
  logic hresetn = 1'b0;
  int   n_run   = 0;
  int   n_fail  = 0;

  renode_ahb_manager_engine_if #(
    .AddressWidth(32),
    .DataWidth(32)
  ) bus ();

  renode_ahb_manager_engine #(
    .AddressWidth(32),
    .DataWidth(32)
  ) dut (
    .hclk(hclk),
    .hresetn(hresetn),
    .bus(bus)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Reference model: where the transfer sits in the AHB
  // pipeline, plus the response it must produce.
  logic        m_a = 1'b0;
  logic        m_d = 1'b0;
  logic        m_r = 1'b0;
  logic        m_write = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;
  logic [2:0]  m_size = '0;
  logic        m_idle;

  assign m_idle = !(m_a || m_d || m_r);

  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      m_a     <= 1'b0;
      m_d     <= 1'b0;
      m_r     <= 1'b0;
      m_err   <= 1'b0;
      m_rdata <= '0;
    end else begin
      if (m_idle && bus.cmd_valid) begin
        m_addr  <= bus.cmd_addr;
        m_write <= bus.cmd_write;
        m_size  <= bus.cmd_size;
        m_wdata <= bus.cmd_wdata;
        if (bus.cmd_size <= 3'd2 &&
            (bus.cmd_addr % (32'd1 << bus.cmd_size)) == 0)
          m_a <= 1'b1;
        else begin
          m_r     <= 1'b1;
          m_err   <= 1'b1;
          m_rdata <= '0;
        end
      end
      if (m_a && bus.hready) begin
        m_a <= 1'b0;
        m_d <= 1'b1;
      end
      if (m_d && bus.hready) begin
        m_d     <= 1'b0;
        m_r     <= 1'b1;
        m_err   <= bus.hresp;
        m_rdata <= (!m_write && !bus.hresp)
                   ? bus.hrdata : 32'h0;
      end
      if (m_r && bus.resp_ready)
        m_r <= 1'b0;
    end
  end

  always @(negedge hclk) begin
    chk("hburst", bus.hburst, 3'b000);
    chk("hprot", bus.hprot, 4'b0011);
    chk("hmastlock", bus.hmastlock, 1'b0);
    chk("cmd_ready", bus.cmd_ready, m_idle && hresetn);
    chk("htrans", bus.htrans, m_a ? 2'b10 : 2'b00);
    chk("resp_valid", bus.resp_valid, m_r);
    if (m_r) begin
      chk("resp_rdata", bus.resp_rdata, m_rdata);
      chk("resp_error", bus.resp_error, m_err);
    end
    if (m_a) begin
      chk("haddr", bus.haddr, m_addr);
      chk("hwrite", bus.hwrite, m_write);
      chk("hsize", bus.hsize, m_size);
    end
    if (m_d)
      chk("hwdata_dp", bus.hwdata,
          m_write ? m_wdata : 32'h0);
    if (m_idle)
      chk("hwdata_idle", bus.hwdata, 32'h0);
    if (!hresetn) begin
      chk("rst_haddr", bus.haddr, 32'h0);
      chk("rst_hwrite", bus.hwrite, 1'b0);
      chk("rst_hsize", bus.hsize, 3'b000);
      chk("rst_rdata", bus.resp_rdata, 32'h0);
      chk("rst_rerr", bus.resp_error, 1'b0);
    end
  end

  task automatic drive(input int k, input int waits,
                       input logic err,
                       input logic [31:0] rd);
    int j;
    if (k == 0) begin
      bus.hready = 1'b1;
      bus.hresp  = 1'b0;
      bus.hrdata = '0;
    end else begin
      j = k - 1;
      if (j < waits) begin
        bus.hready = 1'b0;
        bus.hresp  = err;
        bus.hrdata = 32'hBAD0BAD0;
      end else if (j == waits) begin
        bus.hready = 1'b1;
        bus.hresp  = err;
        bus.hrdata = rd;
      end else begin
        bus.hready = 1'b1;
        bus.hresp  = 1'b0;
        bus.hrdata = '0;
      end
    end
  endtask

  // exp_lat: edges after the accept edge at which
  // resp_valid is first seen (0 = locally rejected).
  task automatic run(input string nm,
                     input logic wr,
                     input logic [31:0] addr,
                     input logic [2:0] sz,
                     input logic [31:0] wd,
                     input int waits,
                     input logic err,
                     input logic [31:0] rd,
                     input int hold,
                     input int exp_lat,
                     input logic [31:0] exp_rd,
                     input logic exp_err);
    int k;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_size  = sz;
    bus.cmd_wdata = wd;
    k = 0;
    while (!bus.cmd_ready && k < 10) begin
      @(posedge hclk);
      #1;
      k++;
    end
    chk({nm, "_accept_to"}, k < 10, 1'b1);
    @(posedge hclk);
    #1;
    bus.cmd_valid = 1'b0;
    if (exp_lat != 0) begin
      chk({nm, "_nonseq"}, bus.htrans, 2'b10);
      chk({nm, "_addr"}, bus.haddr, addr);
    end else
      chk({nm, "_no_xfer"}, bus.htrans, 2'b00);
    k = 0;
    while (!bus.resp_valid && k < 30) begin
      drive(k, waits, err, rd);
      @(posedge hclk);
      #1;
      k++;
      if (k == 1 && exp_lat != 0) begin
        chk({nm, "_idle"}, bus.htrans, 2'b00);
        chk({nm, "_hwdata"}, bus.hwdata,
            wr ? wd : 32'h0);
      end
    end
    chk({nm, "_lat"}, k, exp_lat);
    chk({nm, "_rdata"}, bus.resp_rdata, exp_rd);
    chk({nm, "_err"}, bus.resp_error, exp_err);
    bus.hready = 1'b1;
    bus.hresp  = 1'b0;
    bus.hrdata = '0;
    for (int i = 0; i < hold; i++) begin
      @(posedge hclk);
      #1;
      chk({nm, "_hold_v"}, bus.resp_valid, 1'b1);
      chk({nm, "_hold_d"}, bus.resp_rdata, exp_rd);
      chk({nm, "_hold_cr"}, bus.cmd_ready, 1'b0);
    end
    bus.resp_ready = 1'b1;
    @(posedge hclk);
    #1;
    bus.resp_ready = 1'b0;
    chk({nm, "_done_v"}, bus.resp_valid, 1'b0);
    chk({nm, "_done_cr"}, bus.cmd_ready, 1'b1);
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_size   = '0;
    bus.cmd_wdata  = '0;
    bus.resp_ready = 1'b0;
    bus.hready     = 1'b1;
    bus.hresp      = 1'b0;
    bus.hrdata     = '0;
    repeat (3) @(posedge hclk);
    #1;
    chk("reset_cr", bus.cmd_ready, 1'b0);
    chk("reset_htrans", bus.htrans, 2'b00);
    chk("reset_rv", bus.resp_valid, 1'b0);
    @(negedge hclk);
    #2;
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    chk("post_reset_cr", bus.cmd_ready, 1'b1);

    run("wr0", 1, 32'h1000, 2, 32'hDEADBEEF, 0, 0,
        32'h0, 0, 2, 32'h0, 0);
    run("rd3w", 0, 32'h2000, 2, 32'h0, 3, 0,
        32'h12345678, 0, 5, 32'h12345678, 0);
    run("wrerr", 1, 32'h3000, 2, 32'hCAFEF00D, 1, 1,
        32'h0, 0, 3, 32'h0, 1);
    run("half_mis", 0, 32'h1001, 1, 32'h0, 0, 0,
        32'h0, 0, 0, 32'h0, 1);
    run("dword", 1, 32'h1000, 3, 32'h55, 0, 0,
        32'h0, 0, 0, 32'h0, 1);
    run("rdhold", 0, 32'h4004, 2, 32'h0, 0, 0,
        32'hA5A50F0F, 4, 2, 32'hA5A50F0F, 0);
    run("byte", 0, 32'h4003, 0, 32'h0, 1, 0,
        32'h11000000, 0, 3, 32'h11000000, 0);
    run("rderr", 0, 32'h6000, 2, 32'h0, 1, 1,
        32'hFFFF, 0, 3, 32'h0, 1);
    run("half_ok", 1, 32'h2002, 1, 32'hBEEF0000, 2, 0,
        32'h0, 1, 4, 32'h0, 0);

    // Reset while the read is parked in its data phase.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h5000;
    bus.cmd_size  = 3'd2;
    @(posedge hclk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.hready    = 1'b1;
    @(posedge hclk);
    #1;
    bus.hready = 1'b0;
    @(posedge hclk);
    #3;
    hresetn = 1'b0;
    #1;
    chk("rst6_htrans", bus.htrans, 2'b00);
    chk("rst6_haddr", bus.haddr, 32'h0);
    chk("rst6_hwdata", bus.hwdata, 32'h0);
    chk("rst6_rv", bus.resp_valid, 1'b0);
    chk("rst6_cr", bus.cmd_ready, 1'b0);
    @(negedge hclk);
    #2;
    bus.hready = 1'b1;
    hresetn    = 1'b1;
    @(posedge hclk);
    #1;
    chk("rst6_cr_after", bus.cmd_ready, 1'b1);
    chk("rst6_rv_after", bus.resp_valid, 1'b0);
    repeat (4) @(posedge hclk);
    #1;
    chk("rst6_rv_late", bus.resp_valid, 1'b0);

    run("after_rst", 1, 32'h7000, 2, 32'h01020304, 0, 0,
        32'h0, 0, 2, 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
